// File: rtl/nor_bist_pkg.sv
// nor_bist_pkg: shared FSM state type and the expected NOR truth table for nor_bist.
package nor_bist_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;
   // Bit i is the expected NOR output for {a,b} == i.
   localparam logic [3:0] EXP_TT = 4'b0001;
endpackage

// File: rtl/nor_bist.sv
// nor_bist: sweeps {a,b} over all four vectors for ROUNDS rounds, checks an external NOR gate's output
// and reports the mismatch count, the first failing vector and a pass flag.
module nor_bist
   import nor_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ROUNDS        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       c_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt,
   output logic [1:0] fail_vec
);
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);
   state_t     state, nxt_state;
   logic [1:0] vec, nxt_vec;
   logic [3:0] round, nxt_round;
   logic [3:0] cnt;
   logic       mism;
   assign busy = state != IDLE;
   // c_in is combinational from our own registered a_out/b_out, so no synchronizer is needed.
   assign mism = state == CHECK && c_in != EXP_TT[vec];
   always_comb begin
      nxt_state = state;
      nxt_vec   = vec;
      nxt_round = round;
      case (state)
         IDLE: if (start) begin
            nxt_state = SETTLE;
            nxt_vec   = 2'd0;
            nxt_round = 4'd0;
         end
         SETTLE: if (cnt == 4'd0) nxt_state = CHECK;
         CHECK: if (vec != 2'd3) begin
            nxt_vec   = vec + 2'd1;
            nxt_state = SETTLE;
         end else if (round != RND_LAST) begin
            nxt_vec   = 2'd0;
            nxt_round = round + 4'd1;
            nxt_state = SETTLE;
         end else nxt_state = DONE;
         default: nxt_state = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         vec      <= 2'd0;
         round    <= 4'd0;
         cnt      <= 4'd0;
         a_out    <= 1'b0;
         b_out    <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 8'd0;
         fail_vec <= 2'd0;
      end else begin
         state          <= nxt_state;
         vec            <= nxt_vec;
         round          <= nxt_round;
         {a_out, b_out} <= (nxt_state == SETTLE || nxt_state == CHECK) ? nxt_vec : 2'b00;
         cnt            <= (nxt_state == SETTLE && state != SETTLE) ? CNT_LOAD :
                           (state == SETTLE && cnt != 4'd0) ? cnt - 4'd1 : cnt;
         done           <= state == DONE;
         if (state == IDLE && start) begin
            err_cnt  <= 8'd0;
            fail_vec <= 2'd0;
            pass     <= 1'b0;
         end else if (mism) begin
            err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            fail_vec <= (err_cnt == 8'd0) ? vec : fail_vec;
         end
         if (state == DONE) pass <= err_cnt == 8'd0;
      end
   end
endmodule

// File: tb/tb_nor_bist.sv
// tb_nor_bist: self-checking bench for nor_bist with a truth-table driven external gate model.
module tb_nor_bist;
   logic       clk, rst_n;
   logic       start0, a0, b0, busy0, done0, pass0, c0;
   logic [7:0] err0;
   logic [1:0] fv0;
   logic [3:0] tt0;
   logic       start1, a1, b1, busy1, done1, pass1, c1;
   logic [7:0] err1;
   logic [1:0] fv1;
   logic [3:0] tt1;
   int         checks = 0;
   int         errors = 0;

   assign c0 = tt0[{a0, b0}];
   assign c1 = tt1[{a1, b1}];

   nor_bist dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .c_in(c0), .a_out(a0), .b_out(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
   );
   nor_bist #(.SETTLE_CYCLES(15), .ROUNDS(15)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .c_in(c1), .a_out(a1), .b_out(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tt;
      bit         noisy;
      int         err;
      int         fv;
      int         ps;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: each vector is checked once per round; mismatches are where the gate differs from ~(a|b).
   function automatic void model(input logic [3:0] tt, input int rounds, output int err, output int fv,
                                 output int ps);
      err = 0;
      fv  = 0;
      for (int v = 0; v < 4; v++) begin
         int nor_v;
         nor_v = ((v / 2) | (v % 2)) != 0 ? 0 : 1;
         if (int'(tt[v]) != nor_v) begin
            if (err == 0) fv = v;
            err += rounds;
         end
      end
      if (err > 255) err = 255;
      ps = (err == 0) ? 1 : 0;
   endfunction

   task automatic kick0();
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      chk("busy_after_start", busy0, 1);
      chk("ab_after_start", {a0, b0}, 0);
   endtask

   // Steps edge by edge after a kick; edge k expects vector k/3 on a/b for the default timing.
   task automatic wait_done0(input bit noisy, output int e);
      e = -1;
      for (int k = 1; k <= 40 && e < 0; k++) begin
         if (noisy) start0 = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("ab_seq", {a0, b0}, k < 12 ? k / 3 : 0);
         chk("busy_seq", busy0, k <= 12 ? 1 : 0);
         if (done0) e = k;
      end
      start0 = 1'b0;
   endtask

   task automatic run_check0(input string name, input logic [3:0] tt, input bit noisy, input int exp_err,
                             input int exp_fv, input int exp_ps);
      int e;
      tt0 = tt;
      kick0();
      wait_done0(noisy, e);
      chk({name, "_done_edge"}, e, 13);
      chk({name, "_err_cnt"}, err0, exp_err);
      chk({name, "_fail_vec"}, fv0, exp_fv);
      chk({name, "_pass"}, pass0, exp_ps);
   endtask

   initial begin
      int e, m_err, m_fv, m_ps;
      logic [3:0] rtt;
      tbl[0] = '{4'b0001, 1'b0, 0, 0, 1};
      tbl[1] = '{4'b0000, 1'b0, 1, 0, 0};
      tbl[2] = '{4'b1110, 1'b0, 4, 0, 0};
      tbl[3] = '{4'b0001, 1'b1, 0, 0, 1};
      tbl[4] = '{4'b1111, 1'b1, 3, 1, 0};
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      tt0    = 4'b0001;
      tt1    = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ab", {a0, b0}, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err", err0, 0);
      chk("rst_fv", fv0, 0);
      chk("rst_busy1", busy1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_check0($sformatf("tbl%0d", i), tbl[i].tt, tbl[i].noisy, tbl[i].err,
                                             tbl[i].fv, tbl[i].ps);

      // A start during the done pulse is accepted and clears the previous result.
      tt0 = 4'b0000;
      kick0();
      wait_done0(1'b0, e);
      chk("chain_first_done", e, 13);
      chk("chain_first_err", err0, 1);
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      chk("chain_busy", busy0, 1);
      chk("chain_err_cleared", err0, 0);
      chk("chain_pass_cleared", pass0, 0);
      wait_done0(1'b0, e);
      chk("chain_second_done", e, 13);
      chk("chain_second_err", err0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_err", err0, 1);
      chk("hold_fv", fv0, 0);
      chk("hold_pass", pass0, 0);
      chk("hold_done", done0, 0);

      // Reset during the second vector's settle aborts at once.
      tt0 = 4'b0001;
      kick0();
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_ab", {a0, b0}, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_ab", {a0, b0}, 0);
      chk("abort_busy", busy0, 0);
      chk("abort_err", err0, 0);
      chk("abort_fv", fv0, 0);
      chk("abort_pass", pass0, 0);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         chk("abort_no_done", done0, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_check0("after_rst", 4'b0001, 1'b0, 0, 0, 1);

      for (int i = 0; i < 6; i++) begin
         rtt = 4'($urandom_range(0, 15));
         model(rtt, 1, m_err, m_fv, m_ps);
         run_check0($sformatf("rnd%0d_tt%0h", i, rtt), rtt, 1'($urandom_range(0, 1)), m_err, m_fv, m_ps);
      end

      // Maximum parameters with a stuck-at-1 gate.
      model(tt1, 15, m_err, m_fv, m_ps);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      e = -1;
      for (int k = 1; k <= 1100 && e < 0; k++) begin
         @(posedge clk); #1;
         if (done1) e = k;
      end
      chk("max_done_edge", e, 961);
      chk("max_err_cnt", err1, 45);
      chk("max_err_model", err1, m_err);
      chk("max_fail_vec", fv1, 1);
      chk("max_pass", pass1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/nor_bist.md
NOR_BIST -- requirements
Module: nor_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, cycles held per vector before sampling; legal range 1..15.
REQ-002 The block SHALL have parameter ROUNDS, default 1, number of full 4-vector sweeps per run; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 The block SHALL have port c_in  input  1  output of the external NOR gate under test.
REQ-007 The block SHALL have port a_out  output  1  registered drive to NOR input a.
REQ-008 The block SHALL have port b_out  output  1  registered drive to NOR input b.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse at run end.
REQ-011 The block SHALL have port pass  output  1  result of the last completed run: high iff zero mismatches.
REQ-012 The block SHALL have port err_cnt  output  8  mismatch count of the current or last run, saturating at 255.
REQ-013 The block SHALL have port fail_vec  output  2  {a,b} of the first mismatching vector; 0 if none.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CHECK, DONE.
REQ-015 In IDLE, the block SHALL drive a_out=b_out=0, and start=1 SHALL move the FSM to SETTLE with vector index vec=0, round=0, err_cnt=0, fail_vec=0, pass=0.
REQ-016 The block SHALL ignore start in SETTLE, CHECK and DONE, with no restart and no queueing.
REQ-017 The block SHALL drive {a_out,b_out}=vec throughout SETTLE and CHECK for that vector.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter loaded on entry, then transition to CHECK.
REQ-019 CHECK SHALL last one cycle, sample c_in and compare it to the expected value NOR(vec[1],vec[0]) = 1,0,0,0 for vec 0..3.
REQ-020 On a CHECK mismatch, err_cnt SHALL increment unless it is already 255 (saturate).
REQ-021 On a CHECK mismatch while err_cnt==0, fail_vec SHALL capture vec.
REQ-022 After CHECK with vec<3, vec SHALL increment and the FSM SHALL return to SETTLE.
REQ-023 After CHECK with vec==3 and round<ROUNDS-1, vec SHALL wrap to 0, round SHALL increment and the FSM SHALL return to SETTLE.
REQ-024 After CHECK with vec==3 and round==ROUNDS-1, the FSM SHALL go to DONE.
REQ-025 DONE SHALL last one cycle, assert done=1 and load pass=(err_cnt==0 including the final CHECK's result), then transition to IDLE.
REQ-026 pass, err_cnt and fail_vec SHALL hold after DONE until the next accepted start.
REQ-027 If start is sampled at edge 0, done SHALL be high in the cycle following edge 4*ROUNDS*(SETTLE_CYCLES+1)+1; with defaults, edge 13.
REQ-028 c_in SHALL be used without a synchronizer, because its source is combinational from a_out/b_out on clk.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, and clear the internal counters.
REQ-030 Reset mid-run SHALL abort the run immediately with no done pulse.
REQ-031 Reset release SHALL be synchronous to clk, and the first start SHALL be accepted no earlier than the first edge with rst_n high.

Structure
REQ-032 A shared package nor_bist_pkg SHALL hold the state enum typedef and the 4-entry expected truth-table constant (4'b0001 indexed by vec).
REQ-033 The block SHALL contain no sub-module; the NOR gate under test SHALL be external and instantiated only in the bench.

Verification
REQ-034 The bench SHALL drive good NOR, defaults, start pulse -> a/b sequence 00,01,10,11 each held 3 cycles; done at edge 13; pass=1, err_cnt=0, fail_vec=0.
REQ-035 The bench SHALL drive c_in stuck-at-0 -> mismatch only at vec 0; err_cnt=1, fail_vec=2'b00, pass=0.
REQ-036 The bench SHALL substitute an OR gate (c_in=a|b) -> all 4 vectors mismatch; err_cnt=4, fail_vec=2'b00, pass=0.
REQ-037 The bench SHALL run ROUNDS=15, SETTLE_CYCLES=15, c_in stuck-at-1 -> err_cnt=45 (3 per round), fail_vec=2'b01, done at edge 961.
REQ-038 The bench SHALL assert rst_n low during the 2nd vector's SETTLE -> immediate IDLE, all outputs 0, no done; a fresh start then completes normally.
REQ-039 The bench SHALL pulse start repeatedly while busy -> run timing and results unchanged; start sampled in the cycle after done is accepted and clears err_cnt.
